// File: rtl/mem_responder.sv
// Memory-side responder for the MDR/MAR interface: word RAM with a fixed
// wait-state count, one-cycle Rdy on completion and Err on conflicting requests.
module mem_responder #(
  parameter int unsigned ADDR_WIDTH  = 9,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic [ADDR_WIDTH-1:0] MARaddr,
  input  logic [DATA_WIDTH-1:0] MDRdata,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  output logic [DATA_WIDTH-1:0] Mdatain,
  output logic                  Rdy,
  output logic                  Busy,
  output logic                  Err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } state_e;

  state_e                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]   mdata_q, mdata_d;
  logic                    is_write_q, is_write_d;
  logic                    err_q, err_d;
  logic                    mem_we;

  logic [DATA_WIDTH-1:0]   mem [2**ADDR_WIDTH];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    mdata_d    = mdata_q;
    is_write_d = is_write_q;
    err_d      = 1'b0;
    mem_we     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (MemRead ^ MemWrite) begin
          addr_d     = MARaddr;
          wdata_d    = MDRdata;
          is_write_d = MemWrite;
          cnt_d      = 4'(WAIT_STATES);
          state_d    = S_WAIT;
        end else if (MemRead && MemWrite) begin
          err_d = 1'b1;
        end
      end
      S_WAIT: begin
        // The RAM access happens only on the completion edge, so a reset
        // during WAIT leaves memory untouched.
        if (cnt_q == 4'd0) begin
          state_d = S_DONE;
          if (is_write_q) begin
            mem_we = 1'b1;
          end else begin
            mdata_d = mem[addr_q];
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      mdata_q    <= '0;
      is_write_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      mdata_q    <= mdata_d;
      is_write_q <= is_write_d;
      err_q      <= err_d;
    end
  end

  always_ff @(posedge clock) begin
    if (mem_we && !clear) begin
      mem[addr_q] <= wdata_q;
    end
  end

  assign Mdatain = mdata_q;
  assign Rdy     = (state_q == S_DONE);
  assign Busy    = (state_q != S_IDLE);
  assign Err     = err_q;

endmodule
